// File: rtl/eep_pkg.sv
// Shared types and constants for the SPI calibration-EEPROM responder.
package eep_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DECODE
  } eep_state_t;

  localparam logic [1:0] EEP_OP_RD      = 2'b00;
  localparam logic [1:0] EEP_OP_WR      = 2'b01;
  localparam int         EEP_FRAME_BITS = 16;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall strobes on the synchronized level.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Chain resets low so a line already low at reset never produces a spurious fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_eep_resp.sv
// SPI mode-0 responder emulating a 64x8 calibration EEPROM with 16-bit read/write frames.
// Optional write protection input wp is enabled by defining EEP_WRITE_PROTECT_EN.
module spi_eep_resp
  import eep_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int FRAME_BITS  = EEP_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic SCLK,
  input  logic SS_n,
  input  logic MOSI,
`ifdef EEP_WRITE_PROTECT_EN
  input  logic wp,
`endif
  output logic MISO,
  output logic wr_pulse,
  output logic frm_err
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              CW       = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(FRAME_BITS + 1);

  eep_state_t              state, state_nxt;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    mosi_s;
  logic                    sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [15:0]             rx_shift, tx_shift;
  logic [CW-1:0]           bit_cnt;
  logic                    pend;
  logic [7:0]              mem [DEPTH];
  logic [1:0]              op;
  logic [ADDR_W-1:0]       addr;
  logic                    do_write, rd_load;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk (clk),
    .rst (rst),
    .din (SCLK),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .din (SS_n),
    .rise(ss_rise),
    .fall(ss_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign op     = rx_shift[15:14];
  assign addr   = rx_shift[8 +: ADDR_W];
  assign MISO   = (state == SHIFT) & tx_shift[15];

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_pulse  = 1'b0;
    frm_err   = 1'b0;
    do_write  = 1'b0;
    rd_load   = 1'b0;
    case (state)
      WAIT_IDLE: if (ss_rise) state_nxt = IDLE;
      IDLE:      if (ss_fall || pend) state_nxt = SHIFT;
      SHIFT:     if (ss_rise) state_nxt = DECODE;
      DECODE: begin
        state_nxt = IDLE;
        if (bit_cnt != CNT_FULL) begin
          frm_err = 1'b1;
        end else if (op == EEP_OP_WR) begin
`ifdef EEP_WRITE_PROTECT_EN
          if (wp) begin
            frm_err = 1'b1;
          end else begin
            wr_pulse = 1'b1;
            do_write = 1'b1;
          end
`else
          wr_pulse = 1'b1;
          do_write = 1'b1;
`endif
        end else if (op == EEP_OP_RD) begin
          rd_load = 1'b1;
        end else begin
          frm_err = 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // A select fall seen during DECODE is remembered so back-to-back frames are not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
      pend     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      case (state)
        WAIT_IDLE: pend <= 1'b0;
        IDLE: begin
          if (ss_fall || pend) begin
            bit_cnt <= '0;
            pend    <= 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[14:0], mosi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end
          if (sclk_fall) tx_shift <= {tx_shift[14:0], 1'b0};
        end
        DECODE: begin
          if (ss_fall) pend <= 1'b1;
          if (do_write) mem[addr] <= rx_shift[7:0];
          tx_shift <= rd_load ? {8'h00, mem[addr]} : 16'h0000;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_eep_resp.sv
// Randomized scoreboard bench for spi_eep_resp: pulse and MISO monitors check against a frame-level EEPROM model.
module tb_spi_eep_resp;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst, SCLK, SS_n, MOSI;
  logic MISO, wr_pulse, frm_err;
`ifdef EEP_WRITE_PROTECT_EN
  logic wp;
`endif

  always #5 clk = ~clk;

  spi_eep_resp dut (
    .clk     (clk),
    .rst     (rst),
    .SCLK    (SCLK),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
`ifdef EEP_WRITE_PROTECT_EN
    .wp      (wp),
`endif
    .MISO    (MISO),
    .wr_pulse(wr_pulse),
    .frm_err (frm_err)
  );

  typedef struct {
    logic [15:0] word;
    int          nbits;
    bit          check;
  } miso_exp_t;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  bit          mon_en       = 1'b0;
  logic [7:0]  ref_mem [64];
  logic [15:0] ref_tx;
  miso_exp_t   miso_q [$];
  int          ev_q   [$];
  logic [15:0] cap;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level EEPROM behaviour: 1 = write strobe expected, 2 = frame error expected.
  task automatic model_frame(input logic [15:0] rx, input int nbits, input bit wp_v);
    logic [5:0] a;
    a = rx[13:8];
    if (nbits != 16) begin
      ev_q.push_back(2);
      ref_tx = 16'h0000;
    end else if (rx[15:14] == 2'b01) begin
      if (wp_v) ev_q.push_back(2);
      else begin
        ref_mem[a] = rx[7:0];
        ev_q.push_back(1);
      end
      ref_tx = 16'h0000;
    end else if (rx[15:14] == 2'b00) begin
      ref_tx = {8'h00, ref_mem[a]};
    end else begin
      ev_q.push_back(2);
      ref_tx = 16'h0000;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input int nbits, input int rst_at,
                                input int gap, input bit wp_v);
    miso_exp_t   e;
    logic [31:0] s;
    s       = {ref_tx, 16'h0000};
    e.word  = 16'(s >> (32 - nbits));
    e.nbits = nbits;
    e.check = (rst_at < 0);
    miso_q.push_back(e);
    if (rst_at < 0) model_frame(data[15:0], nbits, wp_v);
    else begin
      for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;
      ref_tx = 16'h0000;
    end
`ifdef EEP_WRITE_PROTECT_EN
    wp = wp_v;
`endif
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = data[i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      if (nbits - i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (gap) @(negedge clk);
    check_output("pulse_drain", 16'(ev_q.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && (wr_pulse || frm_err)) begin
      if (ev_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL pulse_unexpected: got wr=%b err=%b expected none", wr_pulse, frm_err);
      end else begin
        check_output("pulse_kind", 16'(wr_pulse ? (frm_err ? 3 : 1) : 2), 16'(ev_q.pop_front()));
      end
    end
  end

  always @(posedge SCLK) begin
    if (mon_en && SS_n === 1'b0) cap = {cap[14:0], MISO};
  end

  always @(posedge SS_n) begin
    if (mon_en) begin
      if (miso_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL miso_queue: got frame %h expected no frame", cap);
      end else begin
        miso_exp_t e;
        e = miso_q.pop_front();
        if (e.check) check_output("miso_word", cap, e.word);
      end
      cap = 16'h0000;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r, nb, g;
    logic [5:0]  a;
    logic [31:0] d;
    bit          w;
    rst  = 1'b1;
    SCLK = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'b0;
`ifdef EEP_WRITE_PROTECT_EN
    wp   = 1'b0;
`endif
    cap    = 16'h0000;
    ref_tx = 16'h0000;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;
    repeat (4) @(negedge clk);
    check_output("rst_miso", 16'(MISO), 16'd0);
    check_output("rst_wr_pulse", 16'(wr_pulse), 16'd0);
    check_output("rst_frm_err", 16'(frm_err), 16'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b1;

    apply_stimulus(32'h4A5C, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0000, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0A00, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0000, 16, -1, 8, 1'b0);
    apply_stimulus(32'h047F, 12, -1, 8, 1'b0);
    apply_stimulus(32'h0700, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0000, 16, -1, 8, 1'b0);
    apply_stimulus(32'hBF11, 16, -1, 8, 1'b0);
    apply_stimulus(32'h3F00, 16, -1, 8, 1'b0);
    apply_stimulus(32'h7FEE, 16, -1, 5, 1'b0);
    apply_stimulus(32'h3F00, 16, -1, 5, 1'b0);
    apply_stimulus(32'h0000, 16, -1, 8, 1'b0);
    apply_stimulus(32'h4312, 16, 8, 8, 1'b0);
    apply_stimulus(32'h0A00, 16, -1, 8, 1'b0);
    apply_stimulus(32'h4312, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0300, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0000, 16, -1, 8, 1'b0);
`ifdef EEP_WRITE_PROTECT_EN
    apply_stimulus(32'h4201, 16, -1, 8, 1'b1);
    apply_stimulus(32'h0200, 16, -1, 8, 1'b1);
    apply_stimulus(32'h4201, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0200, 16, -1, 8, 1'b0);
    apply_stimulus(32'h0000, 16, -1, 8, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 9));
      a  = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
      nb = 16;
      g  = int'($urandom_range(5, 12));
      w  = 1'b0;
`ifdef EEP_WRITE_PROTECT_EN
      w  = ($urandom_range(0, 3) == 0);
`endif
      if (r <= 3)      d = {16'h0000, 2'b01, a, 8'($urandom)};
      else if (r <= 6) d = {16'h0000, 2'b00, a, 8'($urandom)};
      else if (r == 7) d = {16'h0000, 1'b1, 15'($urandom)};
      else begin
        d = $urandom;
        case ($urandom_range(0, 4))
          0:       nb = 8;
          1:       nb = 12;
          2:       nb = 15;
          3:       nb = 17;
          default: nb = 18;
        endcase
      end
      apply_stimulus(d, nb, -1, g, w);
    end

    check_output("miso_drain", 16'(miso_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/spi_eep_resp.md
Name: spi_eep_resp

Overview:
- SPI responder (slave) that emulates the 64x8 calibration EEPROM at the far end of the command-path SPI master.
- Decodes 16-bit mode-0 frames: write frames store a byte; read frames latch an address, and the addressed byte is shifted back on MISO during the next frame.
- Used as the EEPROM model in system benches and as a synthesizable stand-in on FPGA builds without the real part.

Parameters:
- ADDR_W, 6, EEPROM address width; depth is 2**ADDR_W bytes.
- FRAME_BITS, 16, SCLK bits per valid frame.
- SYNC_STAGES, 2, synchronizer flops on SCLK, SS_n and MOSI.

Ports:
- clk  in  1  system clock, at least 8x SCLK frequency.
- rst  in  1  synchronous reset, active-high.
- SCLK  in  1  SPI clock, asynchronous to clk.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  master-out data, MSB first.
- MISO  out  1  slave-out data, MSB first.
- wr_pulse  out  1  one-clk strobe when a byte is written to the array.
- frm_err  out  1  one-clk strobe when a frame is discarded.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: MISO=0, wr_pulse=0, frm_err=0, tx_shift=16'h0000, rx_shift=0, bit_cnt=0, all memory bytes=8'h00, state=WAIT_IDLE.
- Input synchronization: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCLK and SS_n.
- Mode 0 timing:
  - MOSI is sampled on the SCLK rising edge into rx_shift (shift left).
  - tx_shift shifts left on the SCLK falling edge.
  - MISO = tx_shift[15] while SS_n is low; MISO = 0 otherwise.
- State machine:
  - WAIT_IDLE: wait for synchronized SS_n high, then go to IDLE. This prevents a frame already in progress at reset from being accepted.
  - IDLE: on SS_n fall, clear bit_cnt and go to SHIFT.
  - SHIFT: each SCLK rise increments bit_cnt, saturating at FRAME_BITS+1. On SS_n rise, go to DECODE.
  - DECODE: one cycle, then return to IDLE.
- SCLK edges while SS_n is high are ignored.
- Frame decode in DECODE (rx = rx_shift[15:0]):
  - bit_cnt != FRAME_BITS: frm_err=1. No write; tx_shift loaded with 16'h0000.
  - rx[15:14]=2'b01 (write): mem[rx[13:8]] <= rx[7:0]; wr_pulse=1; tx_shift <= 16'h0000.
  - rx[15:14]=2'b00 (read): tx_shift <= {8'h00, mem[rx[13:8]]}. The read value is the array content at this DECODE cycle.
  - rx[15:14]=2'b1x: frm_err=1; tx_shift <= 16'h0000.
- Latency: wr_pulse and frm_err assert in the DECODE cycle, SYNC_STAGES+1 clk after the SS_n rising edge at the pin.
- Frame spacing: the next frame's SS_n fall must follow at least SYNC_STAGES+3 clk after SS_n rise. A fall arriving during DECODE is taken on the following cycle (the edge is held in a pending flag).
- Read-after-write: a read of an address written in an earlier frame returns the new value.
- Address boundary: an address field of 6'h3F is valid. No wrap beyond the array, since the field width equals ADDR_W.
- Reset during SHIFT or DECODE: any pending write is dropped; state goes to WAIT_IDLE.

Optional Feature:
- Macro: EEP_WRITE_PROTECT_EN.
- When defined:
  - An extra input port wp (1 bit, after MOSI) is added.
  - A write frame decoded while wp=1 does not modify memory, wr_pulse stays 0 and frm_err=1.
  - Read frames are unaffected.
- When undefined: the wp port does not exist and all valid write frames are accepted.

Decomposition:
- Shared package eep_pkg:
  - state enum {WAIT_IDLE, IDLE, SHIFT, DECODE}.
  - Opcode constants EEP_OP_RD=2'b00 and EEP_OP_WR=2'b01.
  - EEP_FRAME_BITS=16.
- One sub-module, spi_edge_sync: parameterized synchronizer plus rise/fall detector, instantiated for SCLK and SS_n. MOSI uses only its synchronizer path.

Test Plan:
1. Write frame 16'h4A5C -> one wr_pulse; mem[0x0A]=8'h5C. Next frame 16'h0000 shifts MISO=16'h0000.
2. Read frame 16'h0A00, then frame 16'h0000 -> MISO bits of the second frame equal 16'h005C. No wr_pulse, no frm_err.
3. Frame of 12 SCLKs carrying 12'h47F -> frm_err pulse. Memory unchanged; the subsequent read of 0x07 returns 8'h00.
4. Frame 16'hBF11 (opcode 2'b10) -> frm_err. mem[0x3F] stays 8'h00; a write of 16'h7FEE then a read of 0x3F returns 8'hEE.
5. Assert rst after 8 SCLKs of write 16'h4312, keep SS_n low through the remaining bits -> no write. First valid frame is accepted only after SS_n goes high then falls again.
6. (EEP_WRITE_PROTECT_EN) wp=1, write 16'h4201 -> frm_err, mem[0x02] stays 8'h00. wp=0, repeat -> wr_pulse, a read returns 8'h01.
